input_data_pipeline: RTL and testbench

//  Elastic, Stages-deep input register pipeline. It is the ingress counterpart of the output delay

---
 rtl/input_data_pipeline.sv | 126 ++++++++++++
 tb/tb_input_data_pipeline.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_data_pipeline.sv
// Elastic valid/ready register pipeline with bubble collapse and clk_en stall.
// Define INPUT_PIPELINE_SKID_EN to add a skid register and a registered in_ready.
module input_data_pipeline #(
    parameter int DataWidth = 32,
    parameter int Stages    = 5,
    localparam int CntWidth = $clog2(Stages + 2)
) (
    input  logic                 clk,
    input  logic                 sclr,
    input  logic                 clk_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] out_data,
    output logic [CntWidth-1:0]  occupancy
);

    logic [Stages-1:0]    v_q, v_d;
    logic [DataWidth-1:0] d_q [Stages];
    logic [DataWidth-1:0] d_d [Stages];
    logic [CntWidth-1:0]  occ_q, occ_d;
    logic [Stages-1:0]    adv;
    logic [Stages-1:0]    load;
    logic [DataWidth-1:0] src0;
    logic                 run;
    logic                 in_xfer;

`ifdef INPUT_PIPELINE_SKID_EN
    logic                 sk_v_q, sk_v_d;
    logic [DataWidth-1:0] sk_d_q, sk_d_d;
    logic                 can0;
`endif

    assign run       = clk_en & ~sclr;
    assign out_valid = v_q[Stages-1] & run;
    assign out_data  = d_q[Stages-1];
    assign occupancy = occ_q;
    assign in_xfer   = in_valid & in_ready;

`ifdef INPUT_PIPELINE_SKID_EN
    assign in_ready  = run & ~sk_v_q;
`else
    assign in_ready  = run & (~v_q[0] | adv[0]);
`endif

    // Advance chain: a valid stage moves on when the stage ahead is empty or leaving.
    always_comb begin
        logic carry;
        adv   = '0;
        carry = v_q[Stages-1] & out_ready & run;
        adv[Stages-1] = carry;
        for (int i = Stages - 2; i >= 0; i--) begin
            carry  = v_q[i] & (~v_q[i+1] | carry) & run;
            adv[i] = carry;
        end
    end

    // Next state: loads from upstream, stage 0 source selection and occupancy count.
    always_comb begin
        load = '0;
        for (int i = 1; i < Stages; i++) begin
            load[i] = adv[i-1];
        end
`ifdef INPUT_PIPELINE_SKID_EN
        can0    = run & (~v_q[0] | adv[0]);
        load[0] = can0 & (sk_v_q | in_xfer);
        src0    = sk_v_q ? sk_d_q : in_data;
        sk_v_d  = sk_v_q;
        sk_d_d  = sk_d_q;
        if (sk_v_q & can0) begin
            sk_v_d = 1'b0;
        end else if (in_xfer & ~can0) begin
            sk_v_d = 1'b1;
            sk_d_d = in_data;
        end
`else
        load[0] = in_xfer;
        src0    = in_data;
`endif
        for (int i = 0; i < Stages; i++) begin
            v_d[i] = load[i] | (v_q[i] & ~adv[i]);
            if (!load[i]) begin
                d_d[i] = d_q[i];
            end else if (i == 0) begin
                d_d[i] = src0;
            end else begin
                d_d[i] = d_q[i-1];
            end
        end
        occ_d = '0;
        for (int i = 0; i < Stages; i++) begin
            occ_d = occ_d + CntWidth'(v_d[i]);
        end
`ifdef INPUT_PIPELINE_SKID_EN
        occ_d = occ_d + CntWidth'(sk_v_d);
`endif
    end

    // State registers: reset clears everything, clk_en low freezes everything.
    always_ff @(posedge clk) begin
        if (sclr) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < Stages; i++) begin
                d_q[i] <= '0;
            end
`ifdef INPUT_PIPELINE_SKID_EN
            sk_v_q <= 1'b0;
            sk_d_q <= '0;
`endif
        end else if (clk_en) begin
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int i = 0; i < Stages; i++) begin
                d_q[i] <= d_d[i];
            end
`ifdef INPUT_PIPELINE_SKID_EN
            sk_v_q <= sk_v_d;
            sk_d_q <= sk_d_d;
`endif
        end
    end

endmodule

// File: tb/tb_input_data_pipeline.sv
// Bench for input_data_pipeline: directed scenarios plus random traffic
// against a word-position queue model of the pipe.
module tb_input_data_pipeline;

    localparam int DW = 32;
    localparam int S  = 5;
    localparam int CW = $clog2(S + 2);
`ifdef INPUT_PIPELINE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          sclr, clk_en, in_valid, in_ready;
    logic          out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] occupancy;

    input_data_pipeline #(.DataWidth(DW), .Stages(S)) dut (
        .clk       (clk),
        .sclr      (sclr),
        .clk_en    (clk_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Model: each held word has a position (-1 = skid, 0..S-1 = stage).
    int            q_pos[$];
    logic [DW-1:0] q_dat[$];
    logic [DW-1:0] m_last;

    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    bit            hold = 1'b0;
    logic [DW-1:0] word_ctr;
    logic [DW-1:0] seen[$];
    int            first_acc, first_val;
    logic          obs_ir, obs_ov;
    logic [DW-1:0] obs_od;
    int            obs_occ;
    int            full_occ;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                      nm, got, exp, cyc);
    endtask

    // Position a newly accepted word would take after this edge.
    function automatic int cand_pos(input bit ordy);
        int prev = S;
        int st = 0;
        if (q_pos.size() > 0 && q_pos[0] == S - 1 && ordy) st = 1;
        for (int i = st; i < q_pos.size(); i++) begin
            int np = q_pos[i] + 1;
            if (np > S - 1) np = S - 1;
            if (np > prev - 1) np = prev - 1;
            prev = np;
        end
        return (prev - 1 < 0) ? prev - 1 : 0;
    endfunction

    task automatic model_edge(input bit iv, input bit ordy, input bit ce,
                              input bit rst, input logic [DW-1:0] din,
                              input bit ir);
        int prev = S;
        if (rst) begin
            q_pos.delete();
            q_dat.delete();
            m_last = '0;
        end else if (ce) begin
            if (q_pos.size() > 0 && q_pos[0] == S - 1 && ordy) begin
                void'(q_pos.pop_front());
                void'(q_dat.pop_front());
            end
            for (int i = 0; i < q_pos.size(); i++) begin
                int np = q_pos[i] + 1;
                if (np > S - 1) np = S - 1;
                if (np > prev - 1) np = prev - 1;
                q_pos[i] = np;
                prev = np;
            end
            if (iv && ir) begin
                q_pos.push_back((prev - 1 < 0) ? prev - 1 : 0);
                q_dat.push_back(din);
            end
            if (q_pos.size() > 0 && q_pos[0] == S - 1) m_last = q_dat[0];
        end
    endtask

    task automatic step(input bit iv_in, input bit ordy, input bit ce,
                        input bit rst);
        bit iv;
        bit e_ir, e_ov;
        iv = iv_in | hold;
        @(negedge clk);
        sclr      = rst;
        clk_en    = ce;
        out_ready = ordy;
        in_valid  = iv;
        in_data   = iv ? word_ctr : DW'($urandom);
        #1;
        if (SKID)
            e_ir = !rst && ce &&
                   !(q_pos.size() > 0 && q_pos[q_pos.size()-1] == -1);
        else
            e_ir = !rst && ce && (cand_pos(ordy) >= 0);
        e_ov = !rst && ce && q_pos.size() > 0 && q_pos[0] == S - 1;
        chk("in_ready", 64'(in_ready), 64'(e_ir));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("out_data", 64'(out_data), 64'(m_last));
        chk("occupancy", 64'(occupancy), 64'(q_pos.size()));
        obs_ir  = in_ready;
        obs_ov  = out_valid;
        obs_od  = out_data;
        obs_occ = int'(occupancy);
        if (out_valid && out_ready) seen.push_back(out_data);
        if (out_valid && first_val < 0) first_val = cyc;
        if (iv && e_ir && first_acc < 0) first_acc = cyc + 1;
        @(posedge clk);
        cyc++;
        model_edge(iv, ordy, ce, rst, word_ctr, e_ir);
        if (iv && e_ir) word_ctr++;
        hold = iv && !e_ir && !rst;
    endtask

    initial begin
        sclr = 1'b1; clk_en = 1'b1; in_valid = 1'b0;
        out_ready = 1'b0; in_data = '0;
        m_last = '0;
        word_ctr = 32'h1;
        first_acc = -1;
        first_val = -1;
        full_occ = SKID ? S + 1 : S;

        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 1, 1, 0);
        chk("reset_occ", 64'(obs_occ), 64'd0);
        chk("reset_out_data", 64'(obs_od), 64'd0);

        // Streaming 0x1..0x8 with the consumer always ready.
        seen.delete();
        first_acc = -1;
        first_val = -1;
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0);
        chk("t1_latency", 64'(first_val - first_acc), 64'(S - 1));
        chk("t1_count", 64'(seen.size()), 64'd8);
        for (int i = 0; i < 8 && i < seen.size(); i++)
            chk("t1_order", 64'(seen[i]), 64'(i + 1));

        // Fill against backpressure, then drain in order.
        seen.delete();
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 1, 0);
            if (!obs_ir) break;
        end
        chk("t2_full_occ", 64'(obs_occ), 64'(full_occ));
        for (int i = 0; i < 14; i++) step(0, 1, 1, 0);
        chk("t2_drain_count", 64'(seen.size()), 64'(full_occ + 1));
        for (int i = 0; i < seen.size(); i++)
            chk("t2_order", 64'(seen[i]), 64'(9 + i));

        // Full pipe with simultaneous in and out transfers.
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 1, 0);
            if (!obs_ir) break;
        end
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        chk("t3_steady_occ", 64'(obs_occ), 64'(S));
        for (int i = 0; i < 14; i++) step(0, 1, 1, 0);

        // Two words separated by a gap collapse at the output end.
        word_ctr = 32'hA;
        step(1, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(1, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        chk("t4_occ", 64'(obs_occ), 64'd2);
        chk("t4_head", 64'(obs_od), 64'hA);
        chk("t4_valid", 64'(obs_ov), 64'd1);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0);

        // Global stall mid-stream.
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0);
            chk("t5_stall_ready", 64'(obs_ir), 64'd0);
            chk("t5_stall_valid", 64'(obs_ov), 64'd0);
        end
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0);

        // Reset with three words held discards them.
        seen.delete();
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 1, 1, 0);
        chk("t6_occ", 64'(obs_occ), 64'd0);
        chk("t6_valid", 64'(obs_ov), 64'd0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0);
        chk("t6_no_emit", 64'(seen.size()), 64'd0);

        // Random traffic.
        word_ctr = DW'($urandom);
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, ($urandom % 3) != 0,
                 ($urandom % 8) != 0, ($urandom % 200) == 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
